// File: rtl/tag_sched.sv
// -----------------------------------------------------------------------------
// tag_sched
//
// Sequencer for a row of caster/PE columns that share one broadcast bus.
// A pass runs in three phases:
//   CONFIG : writes ID (base_id + col) into each caster, one column per cycle.
//   STREAM : accepts num_words words from the input stream and broadcasts
//            each one on the bus with the tag of the column it is meant for,
//            cycling through the columns round-robin.
//   DRAIN  : collects one result per column, in column order, and hands it
//            to the result stream.
// abort cancels a pass in any phase. rst is asynchronous and active-high.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start, abort             pass request (IDLE only) / synchronous cancel
//   base_id, num_words       pass parameters, latched on an accepted start
//   s_valid, s_data, s_ready input word stream
//   id_we, id_wdata          one-hot caster ID write strobe and ID value
//   bus_valid/bus_tag/bus_data  broadcast bus to the casters
//   res_valid, res_data      per-column result valid, OR-combined result data
//   m_valid, m_data, m_ready result stream
//   busy, done               not-IDLE flag, one-cycle completion pulse
// -----------------------------------------------------------------------------
module tag_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ID_WIDTH-1:0]   base_id,
    input  logic [15:0]           num_words,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic [NUM_COL-1:0]    id_we,
    output logic [ID_WIDTH-1:0]   id_wdata,
    output logic                  bus_valid,
    output logic [ID_WIDTH-1:0]   bus_tag,
    output logic [DATA_WIDTH-1:0] bus_data,
    input  logic [NUM_COL-1:0]    res_valid,
    input  logic [DATA_WIDTH-1:0] res_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int               COL_W    = $clog2(NUM_COL);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COL - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONFIG = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t                  state_reg;
    logic [COL_W-1:0]        col_reg;
    logic [15:0]             cnt_reg;
    logic [ID_WIDTH-1:0]     base_id_reg;
    logic [15:0]             num_words_reg;
    logic [NUM_COL-1:0]      id_we_reg;
    logic [ID_WIDTH-1:0]     id_wdata_reg;
    logic                    bus_valid_reg;
    logic [ID_WIDTH-1:0]     bus_tag_reg;
    logic [DATA_WIDTH-1:0]   bus_data_reg;
    logic                    m_valid_reg;
    logic [DATA_WIDTH-1:0]   m_data_reg;
    logic                    done_reg;

    // Column index after one step, wrapping at the last column.
    logic [COL_W-1:0]        col_next;
    // Tag of the current column and of the next column.
    logic [ID_WIDTH-1:0]     tag_cur;
    logic [ID_WIDTH-1:0]     tag_next;
    // One-hot decode of col_next, used as the next caster write strobe.
    logic [NUM_COL-1:0]      we_next;
    // res_valid masked down to the column currently being drained.
    logic [NUM_COL-1:0]      res_sel;
    logic                    res_hit;
    logic                    s_fire;
    logic                    m_fire;
    logic                    last_word;

    assign col_next  = (col_reg == LAST_COL) ? '0 : col_reg + COL_W'(1);
    assign tag_cur   = base_id_reg + ID_WIDTH'(col_reg);
    assign tag_next  = base_id_reg + ID_WIDTH'(col_next);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COL; gi++) begin : g_col
            assign we_next[gi] = (col_next == COL_W'(gi));
            assign res_sel[gi] = res_valid[gi] && (col_reg == COL_W'(gi));
        end
    endgenerate

    assign res_hit   = |res_sel;
    assign s_ready   = (state_reg == STREAM);
    assign s_fire    = s_valid && s_ready;
    assign m_fire    = m_valid_reg && m_ready;
    assign last_word = (cnt_reg == num_words_reg - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            col_reg       <= '0;
            cnt_reg       <= '0;
            base_id_reg   <= '0;
            num_words_reg <= '0;
            id_we_reg     <= '0;
            id_wdata_reg  <= '0;
            bus_valid_reg <= 1'b0;
            bus_tag_reg   <= '0;
            bus_data_reg  <= '0;
            m_valid_reg   <= 1'b0;
            m_data_reg    <= '0;
            done_reg      <= 1'b0;
        end else if (abort) begin
            // Cancel takes priority over start and over any handshake; the
            // block returns to exactly its post-reset condition.
            state_reg     <= IDLE;
            col_reg       <= '0;
            cnt_reg       <= '0;
            base_id_reg   <= '0;
            num_words_reg <= '0;
            id_we_reg     <= '0;
            id_wdata_reg  <= '0;
            bus_valid_reg <= 1'b0;
            bus_tag_reg   <= '0;
            bus_data_reg  <= '0;
            m_valid_reg   <= 1'b0;
            m_data_reg    <= '0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    bus_valid_reg <= 1'b0;
                    if (start) begin
                        if (num_words != 16'd0) begin
                            state_reg     <= CONFIG;
                            col_reg       <= '0;
                            cnt_reg       <= '0;
                            base_id_reg   <= base_id;
                            num_words_reg <= num_words;
                            // Column 0 is written during the first CONFIG cycle.
                            id_we_reg     <= NUM_COL'(1);
                            id_wdata_reg  <= base_id;
                        end else begin
                            // Empty pass: report completion without running.
                            done_reg <= 1'b1;
                        end
                    end
                end

                CONFIG: begin
                    bus_valid_reg <= 1'b0;
                    if (col_reg == LAST_COL) begin
                        state_reg    <= STREAM;
                        col_reg      <= '0;
                        id_we_reg    <= '0;
                        id_wdata_reg <= '0;
                    end else begin
                        col_reg      <= col_next;
                        id_we_reg    <= we_next;
                        id_wdata_reg <= tag_next;
                    end
                end

                STREAM: begin
                    // bus_data/bus_tag hold their last broadcast when idle.
                    bus_valid_reg <= s_fire;
                    if (s_fire) begin
                        bus_data_reg <= s_data;
                        bus_tag_reg  <= tag_cur;
                        cnt_reg      <= cnt_reg + 16'd1;
                        if (last_word) begin
                            state_reg <= DRAIN;
                            col_reg   <= '0;
                        end else begin
                            col_reg   <= col_next;
                        end
                    end
                end

                DRAIN: begin
                    bus_valid_reg <= 1'b0;
                    if (m_fire) begin
                        m_valid_reg <= 1'b0;
                        if (col_reg == LAST_COL) begin
                            state_reg <= IDLE;
                            col_reg   <= '0;
                            done_reg  <= 1'b1;
                        end else begin
                            col_reg     <= col_next;
                            // Tag follows the column on the same edge it moves.
                            bus_tag_reg <= tag_next;
                        end
                    end else begin
                        // The first DRAIN cycle still shows the last streamed
                        // word's tag; from here on the tag tracks col.
                        bus_tag_reg <= tag_cur;
                        if (!m_valid_reg && res_hit) begin
                            m_valid_reg <= 1'b1;
                            m_data_reg  <= res_data;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign id_we     = id_we_reg;
    assign id_wdata  = id_wdata_reg;
    assign bus_valid = bus_valid_reg;
    assign bus_tag   = bus_tag_reg;
    assign bus_data  = bus_data_reg;
    assign m_valid   = m_valid_reg;
    assign m_data    = m_data_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;

endmodule

// File: tb/tb_tag_sched.sv
// -----------------------------------------------------------------------------
// tb_tag_sched
//
// Drives whole passes through tag_sched and predicts the outcome from the
// pass description: the list of ID writes (base+k), the list of broadcast
// words with tags base+(i mod NUM_COL), and the list of results collected
// in column order. Input timing (s_valid, m_ready, res_valid) is random.
// -----------------------------------------------------------------------------
module tb_tag_sched;

    localparam int DW = 16;
    localparam int NC = 4;
    localparam int IW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [IW-1:0] base_id;
    logic [15:0]   num_words;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic [NC-1:0] id_we;
    logic [IW-1:0] id_wdata;
    logic          bus_valid;
    logic [IW-1:0] bus_tag;
    logic [DW-1:0] bus_data;
    logic [NC-1:0] res_valid;
    logic [DW-1:0] res_data;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;

    tag_sched #(
        .DATA_WIDTH (DW),
        .NUM_COL    (NC),
        .ID_WIDTH   (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .base_id   (base_id),
        .num_words (num_words),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .id_we     (id_we),
        .id_wdata  (id_wdata),
        .bus_valid (bus_valid),
        .bus_tag   (bus_tag),
        .bus_data  (bus_data),
        .res_valid (res_valid),
        .res_data  (res_data),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Every output at its reset value.
    task automatic chk_quiet(input string tag);
        chk({tag, "_s_ready"},   32'(s_ready),   0);
        chk({tag, "_id_we"},     32'(id_we),     0);
        chk({tag, "_id_wdata"},  32'(id_wdata),  0);
        chk({tag, "_bus_valid"}, 32'(bus_valid), 0);
        chk({tag, "_bus_tag"},   32'(bus_tag),   0);
        chk({tag, "_bus_data"},  32'(bus_data),  0);
        chk({tag, "_m_valid"},   32'(m_valid),   0);
        chk({tag, "_m_data"},    32'(m_data),    0);
        chk({tag, "_busy"},      32'(busy),      0);
        chk({tag, "_done"},      32'(done),      0);
    endtask

    // One pass. pv/pr/ph: percent chance of s_valid, m_ready and of the
    // current column's res_valid per cycle. inject: 0 none, 1 abort after
    // two streamed words, 2 reset in the third DRAIN cycle.
    task automatic run_pass(input logic [IW-1:0] base, input int nw, input int pv,
                            input int pr, input int ph, input int inject);
        logic [DW-1:0] resp [NC];
        logic [DW-1:0] got [$];
        logic [DW-1:0] exp_data;
        logic [IW-1:0] exp_tag;
        logic [DW-1:0] exp_m;
        logic [DW-1:0] g;
        logic [NC-1:0] rv;
        bit            prev_hs;
        bit            have_prev;
        bit            pending;
        bit            finished;
        int            sent;
        int            mcol;
        int            guard;

        exp_data = '0;
        exp_tag  = '0;
        exp_m    = '0;
        for (int k = 0; k < NC; k++) resp[k] = DW'($urandom);

        start     = 1'b1;
        base_id   = base;
        num_words = 16'(nw);
        step();
        start     = 1'b0;
        base_id   = IW'($urandom);
        num_words = 16'($urandom);

        if (nw == 0) begin
            chk("zero_done",  32'(done),  1);
            chk("zero_busy",  32'(busy),  0);
            chk("zero_id_we", 32'(id_we), 0);
            step();
            chk("zero_done_pulse", 32'(done), 0);
            chk("zero_busy2",      32'(busy), 0);
            return;
        end

        // Caster ID programming, one column per cycle.
        for (int k = 0; k < NC; k++) begin
            chk("cfg_busy",     32'(busy),     1);
            chk("cfg_id_we",    32'(id_we),    32'(1) << k);
            chk("cfg_id_wdata", 32'(id_wdata), 32'(IW'(base + IW'(k))));
            chk("cfg_s_ready",  32'(s_ready),  0);
            chk("cfg_done",     32'(done),     0);
            start = 1'($urandom);
            step();
        end
        start = 1'b0;

        // Word streaming: word i goes out tagged base + (i mod NC).
        sent      = 0;
        guard     = 0;
        prev_hs   = 1'b0;
        have_prev = 1'b0;
        while (sent < nw && guard < 3000) begin
            guard++;
            chk("str_s_ready",   32'(s_ready),   1);
            chk("str_busy",      32'(busy),      1);
            chk("str_id_we",     32'(id_we),     0);
            chk("str_m_valid",   32'(m_valid),   0);
            chk("str_bus_valid", 32'(bus_valid), 32'(prev_hs));
            if (have_prev) begin
                chk("str_bus_data", 32'(bus_data), 32'(exp_data));
                chk("str_bus_tag",  32'(bus_tag),  32'(exp_tag));
            end
            if (inject == 1 && sent == 2) begin
                abort   = 1'b1;
                start   = 1'b1;
                s_valid = 1'b1;
                s_data  = '1;
                step();
                abort   = 1'b0;
                start   = 1'b0;
                s_valid = 1'b0;
                chk_quiet("abort");
                step();
                chk("abort_done", 32'(done), 0);
                chk("abort_busy", 32'(busy), 0);
                return;
            end
            s_valid   = ($urandom_range(99) < pv);
            s_data    = DW'($urandom);
            start     = 1'($urandom);
            res_valid = NC'($urandom);
            m_ready   = 1'($urandom);
            prev_hs   = s_valid;
            if (s_valid) begin
                exp_data  = s_data;
                exp_tag   = IW'(base + IW'(sent % NC));
                have_prev = 1'b1;
                sent++;
            end
            step();
        end
        s_valid = 1'b0;
        start   = 1'b0;
        chk("str_count", 32'(sent), 32'(nw));

        // Result collection, one column at a time in order.
        mcol     = 0;
        pending  = 1'b0;
        finished = 1'b0;
        guard    = 0;
        while (!finished && guard < 3000) begin
            if (guard == 0) begin
                chk("drn_last_valid", 32'(bus_valid), 1);
                chk("drn_last_data",  32'(bus_data),  32'(exp_data));
                chk("drn_last_tag",   32'(bus_tag),   32'(exp_tag));
            end else begin
                chk("drn_bus_valid", 32'(bus_valid), 0);
                chk("drn_bus_tag",   32'(bus_tag),   32'(IW'(base + IW'(mcol))));
            end
            guard++;
            chk("drn_s_ready", 32'(s_ready), 0);
            chk("drn_busy",    32'(busy),    1);
            chk("drn_done",    32'(done),    0);
            chk("drn_m_valid", 32'(m_valid), 32'(pending));
            if (pending) chk("drn_m_data", 32'(m_data), 32'(exp_m));
            if (inject == 2 && guard == 3) begin
                rst = 1'b1;
                #1;
                chk_quiet("rst");
                step();
                rst       = 1'b0;
                res_valid = '0;
                m_ready   = 1'b0;
                start     = 1'b0;
                step();
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done", 32'(done), 0);
                return;
            end
            m_ready   = ($urandom_range(99) < pr);
            rv        = NC'($urandom);
            rv[mcol]  = ($urandom_range(99) < ph);
            res_valid = rv;
            res_data  = rv[mcol] ? resp[mcol] : DW'($urandom);
            start     = 1'($urandom);
            if (pending && m_ready) begin
                got.push_back(m_data);
                pending = 1'b0;
                if (mcol == NC - 1) finished = 1'b1;
                else mcol++;
            end else if (!pending && rv[mcol]) begin
                pending = 1'b1;
                exp_m   = resp[mcol];
            end
            step();
        end
        res_valid = '0;
        m_ready   = 1'b0;
        start     = 1'b0;
        chk("drn_finished", 32'(finished), 1);
        chk("end_done",     32'(done),     1);
        chk("end_busy",     32'(busy),     0);
        chk("end_m_valid",  32'(m_valid),  0);
        for (int k = 0; k < NC; k++) begin
            g = (k < got.size()) ? got[k] : 'x;
            chk("res_order", 32'(g), 32'(resp[k]));
        end
        step();
        chk("end_done_pulse", 32'(done), 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        base_id   = '0;
        num_words = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        res_valid = '0;
        res_data  = '0;
        m_ready   = 1'b0;
        #2;
        chk_quiet("reset");
        step();
        rst = 1'b0;
        step();
        chk_quiet("idle");

        run_pass(4'd3,  6, 100, 100, 100, 0);   // config 3..6, tags 3,4,5,6,3,4
        run_pass(4'd15, 5, 100, 100, 100, 0);   // tag wrap 15,0,1,2
        run_pass(4'd9,  0, 100, 100, 100, 0);   // empty pass
        run_pass(4'd3,  7,  50,  30,  50, 0);   // backpressure on both sides
        run_pass(4'd5,  9,  80, 100, 100, 1);   // abort mid-stream
        run_pass(4'd2,  6, 100,  20,  50, 2);   // reset mid-drain
        run_pass(4'd7,  1, 100, 100, 100, 0);   // single word

        for (int p = 0; p < 8; p++) begin
            run_pass(IW'($urandom), int'($urandom_range(20, 1)),
                     int'($urandom_range(100, 30)), int'($urandom_range(100, 20)),
                     int'($urandom_range(100, 30)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tag_sched.md
TAG_SCHED -- requirements
Module: tag_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 16: bus and result word width.
REQ-002 Parameter NUM_COL, default 4: number of caster/PE columns sequenced, range 2..16.
REQ-003 Parameter ID_WIDTH, default 4: width of PE ID and tag.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 start  in  1  one-cycle pass request; sampled only in IDLE.
REQ-007 abort  in  1  synchronous cancel of current pass.
REQ-008 base_id  in  ID_WIDTH  ID of column 0; latched on accepted start.
REQ-009 num_words  in  16  input words per pass; latched on accepted start.
REQ-010 s_valid  in  1; s_data  in  DATA_WIDTH; s_ready  out  1: input stream from weight/data buffer.
REQ-011 id_we  out  NUM_COL  one-hot ID write strobe per caster.
REQ-012 id_wdata  out  ID_WIDTH  ID value written during CONFIG.
REQ-013 bus_valid  out  1  broadcast word valid (drives casters' CASTER_READY).
REQ-014 bus_tag  out  ID_WIDTH  tag compared by every caster against its ID.
REQ-015 bus_data  out  DATA_WIDTH  broadcast word.
REQ-016 res_valid  in  NUM_COL  per-column PE_VALID from casters.
REQ-017 res_data  in  DATA_WIDTH  OR-combined caster output bus.
REQ-018 m_valid  out  1; m_data  out  DATA_WIDTH; m_ready  in  1: result stream.
REQ-019 busy  out  1  high in any state other than IDLE.
REQ-020 done  out  1  one-cycle pulse at normal pass completion.

Function
REQ-021 States SHALL be IDLE, CONFIG, STREAM, DRAIN; column index col (0..NUM_COL-1) and 16-bit word counter cnt shared by all states.
REQ-022 IDLE: start=1 and num_words!=0 -> CONFIG, col=0, cnt=0, base_id/num_words latched; start=1 and num_words==0 -> done pulse next cycle, remain IDLE.
REQ-023 CONFIG: one column per cycle; id_we bit col=1, id_wdata=(base_id+col) mod 2^ID_WIDTH; after col=NUM_COL-1 -> STREAM, col=0; CONFIG lasts exactly NUM_COL cycles.
REQ-024 STREAM: s_ready=1 combinationally; all other states s_ready=0.
REQ-025 On s_valid&&s_ready: next cycle bus_valid=1, bus_data=s_data, bus_tag=(base_id+col) mod 2^ID_WIDTH; latency 1 cycle; no handshake -> bus_valid=0 next cycle, bus_data/bus_tag hold.
REQ-026 Each STREAM handshake: col increments, wrapping NUM_COL-1 -> 0; cnt increments.
REQ-027 Handshake with cnt==num_words-1 -> DRAIN, col=0; num_words not a multiple of NUM_COL is legal.
REQ-028 DRAIN: bus_valid=0; bus_tag=(base_id+col) mod 2^ID_WIDTH, updated the cycle col changes.
REQ-029 DRAIN with m_valid=0 and res_valid[col]=1: next cycle m_valid=1, m_data=res_data; res_valid of other columns ignored.
REQ-030 m_valid/m_data SHALL hold stable until m_valid&&m_ready; on that handshake m_valid=0 and col increments.
REQ-031 Handshake at col=NUM_COL-1 -> IDLE with done=1 in the same next cycle.
REQ-032 start while busy SHALL be ignored.
REQ-033 abort=1 in any state: next cycle IDLE, all outputs at reset values, no done; abort wins over simultaneous start or handshake.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, col=0, cnt=0, latched base_id/num_words=0, and s_ready, id_we, id_wdata, bus_valid, bus_tag, bus_data, m_valid, m_data, busy, done all 0.
REQ-035 Reset mid-pass SHALL discard the pass; first edge after rst release performs normal IDLE behaviour.

Verification
REQ-036 Config: NUM_COL=4, base_id=3, start -> id_we 0001,0010,0100,1000 on 4 consecutive cycles with id_wdata 3,4,5,6; busy=1.
REQ-037 Stream: num_words=6, s_valid always 1, s_data 10..15 -> bus_valid 6 cycles, bus_tag 3,4,5,6,3,4, each 1 cycle after handshake; then DRAIN.
REQ-038 Backpressure: s_valid toggles 1,0,1 -> bus_valid 1,0,1, cnt advances only on handshakes; in DRAIN m_ready held 0 for 3 cycles -> m_data stable, col unchanged.
REQ-039 Drain: res_valid asserted for col 0..3 with res_data 0xA0..0xA3, m_ready=1 -> m_data 0xA0..0xA3 in order, bus_tag 3..6, done one cycle after last, busy=0.
REQ-040 Boundaries: num_words=0 start -> done pulse, no CONFIG; base_id=15, ID_WIDTH=4 -> tags 15,0,1,2; abort mid-STREAM -> IDLE, no done; rst mid-DRAIN -> all outputs 0 immediately.
